// File: rtl/l1_ahb_mtx_in_stage.sv
// Bus-matrix slave-interface input stage.
// Captures each accepted AHB address phase. When the output stage does not
// serve this port in the same cycle, it stalls the master and replays the
// captured transfer toward the decoder until the port is granted.
//
// state | meaning
// PASS  | live master address/control forwarded, decoder response returned
// HELD  | captured transfer replayed, master stalled with OKAY
module l1_ahb_mtx_in_stage #(
  parameter int AW      = 32,
  parameter int DEC_LSB = 10,
  parameter int UW      = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [AW-1:0]         HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic [UW-1:0]         HAUSERS,
  input  logic                  HREADYS,
  input  logic                  active_dec,
  input  logic                  readyout_dec,
  input  logic [1:0]            resp_dec,
  output logic                  sel_dec,
  output logic [AW-DEC_LSB-1:0] decode_addr_dec,
  output logic [AW-1:0]         addr_in,
  output logic [1:0]            trans_dec,
  output logic                  write_in,
  output logic [2:0]            size_in,
  output logic [2:0]            burst_in,
  output logic [3:0]            prot_in,
  output logic                  mastlock_in,
  output logic [UW-1:0]         auser_in,
  output logic                  ready_in,
  output logic                  held_tran,
  output logic                  HREADYOUTS,
  output logic [1:0]            HRESPS
);

  typedef enum logic {PASS, HELD} state_t;

  state_t        state;
  logic [AW-1:0] h_addr;
  logic [1:0]    h_trans;
  logic          h_write;
  logic [2:0]    h_size;
  logic [2:0]    h_burst;
  logic [3:0]    h_prot;
  logic          h_lock;
  logic [UW-1:0] h_auser;

  logic acc;
  logic is_held;

  assign acc = HSELS & HTRANSS[1] & HREADYS;

  // Reset forces the stage transparent even before the first clock edge.
  assign is_held = (state == HELD) & ~HRESET;

  // FSM plus holding register; the register only loads from the live bus in PASS.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= PASS;
      h_addr  <= '0;
      h_trans <= '0;
      h_write <= 1'b0;
      h_size  <= '0;
      h_burst <= '0;
      h_prot  <= '0;
      h_lock  <= 1'b0;
      h_auser <= '0;
    end else begin
      case (state)
        PASS: begin
          if (acc) begin
            h_addr  <= HADDRS;
            h_trans <= HTRANSS;
            h_write <= HWRITES;
            h_size  <= HSIZES;
            h_burst <= HBURSTS;
            h_prot  <= HPROTS;
            h_lock  <= HMASTLOCKS;
            h_auser <= HAUSERS;
            if (!active_dec) state <= HELD;
          end
        end
        HELD: begin
          if (active_dec) state <= PASS;
        end
        default: state <= PASS;
      endcase
    end
  end

  // Select live or held address/control toward the decoder and bus switch.
  always_comb begin
    if (is_held) begin
      addr_in     = h_addr;
      trans_dec   = h_trans;
      write_in    = h_write;
      size_in     = h_size;
      burst_in    = h_burst;
      prot_in     = h_prot;
      mastlock_in = h_lock;
      auser_in    = h_auser;
      sel_dec     = 1'b1;
      ready_in    = 1'b1;
    end else begin
      addr_in     = HADDRS;
      trans_dec   = HRESET ? 2'b00 : HTRANSS;
      write_in    = HWRITES;
      size_in     = HSIZES;
      burst_in    = HBURSTS;
      prot_in     = HPROTS;
      mastlock_in = HMASTLOCKS;
      auser_in    = HAUSERS;
      sel_dec     = HSELS & ~HRESET;
      ready_in    = HREADYS;
    end
  end

  assign decode_addr_dec = addr_in[AW-1:DEC_LSB];

  // Master-side response: stall with OKAY while replaying, otherwise pass the decoder through.
  always_comb begin
    if (HRESET) begin
      HREADYOUTS = 1'b1;
      HRESPS     = 2'b00;
    end else if (is_held) begin
      HREADYOUTS = 1'b0;
      HRESPS     = 2'b00;
    end else begin
      HREADYOUTS = readyout_dec;
      HRESPS     = resp_dec;
    end
  end

  assign held_tran = is_held;

endmodule

// File: tb/tb_l1_ahb_mtx_in_stage.sv
// Directed bench for l1_ahb_mtx_in_stage with a transfer-level model and
// an in-order scoreboard of address phases delivered to the decoder.
module tb_l1_ahb_mtx_in_stage;

  localparam int AW = 32;
  localparam int DL = 10;
  localparam int UW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSELS;
  logic [AW-1:0] HADDRS;
  logic [1:0]    HTRANSS;
  logic          HWRITES;
  logic [2:0]    HSIZES;
  logic [2:0]    HBURSTS;
  logic [3:0]    HPROTS;
  logic          HMASTLOCKS;
  logic [UW-1:0] HAUSERS;
  logic          HREADYS;
  logic          active_dec;
  logic          readyout_dec;
  logic [1:0]    resp_dec;
  logic          sel_dec;
  logic [AW-DL-1:0] decode_addr_dec;
  logic [AW-1:0] addr_in;
  logic [1:0]    trans_dec;
  logic          write_in;
  logic [2:0]    size_in;
  logic [2:0]    burst_in;
  logic [3:0]    prot_in;
  logic          mastlock_in;
  logic [UW-1:0] auser_in;
  logic          ready_in;
  logic          held_tran;
  logic          HREADYOUTS;
  logic [1:0]    HRESPS;

  int checks = 0;
  int errors = 0;

  l1_ahb_mtx_in_stage #(.AW(AW), .DEC_LSB(DL), .UW(UW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HAUSERS(HAUSERS), .HREADYS(HREADYS),
    .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
    .sel_dec(sel_dec), .decode_addr_dec(decode_addr_dec), .addr_in(addr_in),
    .trans_dec(trans_dec), .write_in(write_in), .size_in(size_in), .burst_in(burst_in),
    .prot_in(prot_in), .mastlock_in(mastlock_in), .auser_in(auser_in),
    .ready_in(ready_in), .held_tran(held_tran), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- transfer-level model ----------------
  // A transfer accepted while not granted becomes "pending"; while pending the
  // decoder sees it and the master is stalled. Every accepted transfer must
  // reach the decoder exactly once, in order, unless reset drops it.
  bit            pend_v = 1'b0;
  logic [AW-1:0] p_addr;
  logic [1:0]    p_trans;
  logic          p_write;
  logic [2:0]    p_size, p_burst;
  logic [3:0]    p_prot;
  logic          p_lock;
  logic [UW-1:0] p_auser;
  logic [AW-1:0] exp_q[$];
  int            n_deliv = 0;

  always @(negedge HCLK) begin
    logic          e_sel, e_ready, e_held, e_hro, e_write, e_lock;
    logic [1:0]    e_trans, e_resp;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_size, e_burst;
    logic [3:0]    e_prot;
    logic [UW-1:0] e_auser;
    logic          acc_m;
    logic [AW-1:0] front;

    e_addr = HADDRS; e_trans = HTRANSS; e_write = HWRITES; e_size = HSIZES;
    e_burst = HBURSTS; e_prot = HPROTS; e_lock = HMASTLOCKS; e_auser = HAUSERS;
    e_sel = HSELS; e_ready = HREADYS; e_held = 1'b0; e_hro = readyout_dec; e_resp = resp_dec;
    if (HRESET) begin
      e_sel = 1'b0; e_trans = 2'b00; e_hro = 1'b1; e_resp = 2'b00;
    end else if (pend_v) begin
      e_addr = p_addr; e_trans = p_trans; e_write = p_write; e_size = p_size;
      e_burst = p_burst; e_prot = p_prot; e_lock = p_lock; e_auser = p_auser;
      e_sel = 1'b1; e_ready = 1'b1; e_held = 1'b1; e_hro = 1'b0; e_resp = 2'b00;
    end

    chk("sel_dec",     64'(sel_dec),         64'(e_sel));
    chk("decode_addr", 64'(decode_addr_dec), 64'(e_addr >> DL));
    chk("addr_in",     64'(addr_in),         64'(e_addr));
    chk("trans_dec",   64'(trans_dec),       64'(e_trans));
    chk("write_in",    64'(write_in),        64'(e_write));
    chk("size_in",     64'(size_in),         64'(e_size));
    chk("burst_in",    64'(burst_in),        64'(e_burst));
    chk("prot_in",     64'(prot_in),         64'(e_prot));
    chk("mastlock_in", 64'(mastlock_in),     64'(e_lock));
    chk("auser_in",    64'(auser_in),        64'(e_auser));
    chk("ready_in",    64'(ready_in),        64'(e_ready));
    chk("held_tran",   64'(held_tran),       64'(e_held));
    chk("HREADYOUTS",  64'(HREADYOUTS),      64'(e_hro));
    chk("HRESPS",      64'(HRESPS),          64'(e_resp));

    acc_m = HSELS & HTRANSS[1] & HREADYS;
    if (HRESET) begin
      exp_q.delete();
    end else begin
      if (!pend_v && acc_m) exp_q.push_back(HADDRS);
      if (sel_dec && trans_dec[1] && ready_in && active_dec) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          chk("deliver_unexpected", 64'(addr_in), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          front = exp_q.pop_front();
          chk("deliver_order", 64'(addr_in), 64'(front));
        end
      end
    end

    if (HRESET) pend_v = 1'b0;
    else if (pend_v) begin
      if (active_dec) pend_v = 1'b0;
    end else if (acc_m && !active_dec) begin
      pend_v = 1'b1;
      p_addr = HADDRS; p_trans = HTRANSS; p_write = HWRITES; p_size = HSIZES;
      p_burst = HBURSTS; p_prot = HPROTS; p_lock = HMASTLOCKS; p_auser = HAUSERS;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic sel, input logic [1:0] tr, input logic [AW-1:0] a,
                       input logic wr, input logic rdy, input logic act,
                       input logic rdy_d, input logic [1:0] rsp, input logic [2:0] bst);
    HSELS = sel; HTRANSS = tr; HADDRS = a; HWRITES = wr; HREADYS = rdy;
    active_dec = act; readyout_dec = rdy_d; resp_dec = rsp; HBURSTS = bst;
    HSIZES = 3'b010; HPROTS = a[3:0] ^ 4'hA; HMASTLOCKS = wr; HAUSERS = ~a;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    int hcnt;
    logic [AW-1:0] ba;

    HRESET = 1'b1;
    drive(1'b1, 2'b10, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'b000);
    #2;
    chk("rst_hreadyout", 64'(HREADYOUTS), 64'd1);
    chk("rst_sel",       64'(sel_dec),    64'd0);
    chk("rst_trans",     64'(trans_dec),  64'd0);
    chk("rst_resp",      64'(HRESPS),     64'd0);
    tick(); tick();
    HRESET = 1'b0;

    // 1: accepted and granted in the same cycle
    drive(1'b1, 2'b10, 32'h2000_0010, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000);
    #2;
    chk("t1_sel",    64'(sel_dec),         64'd1);
    chk("t1_decode", 64'(decode_addr_dec), 64'h08_0000);
    chk("t1_held",   64'(held_tran),       64'd0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000);
    #2;
    chk("t1_stay_pass", 64'(held_tran), 64'd0);
    tick();

    // 2: write held three cycles, granted in the third held cycle
    drive(1'b1, 2'b10, 32'h6000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000);
    #2;
    chk("t2_acc_hro", 64'(HREADYOUTS), 64'd1);
    tick();
    hcnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, (i == 2), 1'b1, 2'b00, 3'b000);
      #2;
      if (held_tran) hcnt++;
      chk("t2_hro",   64'(HREADYOUTS), 64'd0);
      chk("t2_trans", 64'(trans_dec),  64'h2);
      chk("t2_addr",  64'(addr_in),    64'h6000_0000);
      chk("t2_write", 64'(write_in),   64'd1);
      tick();
    end
    chk("t2_held_cycles", 64'(hcnt), 64'd3);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000);
    #2;
    chk("t2_dp_wait", 64'(HREADYOUTS), 64'd0);
    chk("t2_dp_held", 64'(held_tran),  64'd0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000);
    #2;
    chk("t2_dp_done", 64'(HREADYOUTS), 64'd1);
    tick();

    // 3: IDLE is never held
    drive(1'b1, 2'b00, 32'h3000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
    #2;
    chk("t3_hro0", 64'(HREADYOUTS), 64'd0);
    tick();
    drive(1'b1, 2'b00, 32'h3000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000);
    #2;
    chk("t3_held", 64'(held_tran),  64'd0);
    chk("t3_hro1", 64'(HREADYOUTS), 64'd1);
    tick();

    // 4: reset while HELD drops the transfer
    drive(1'b1, 2'b10, 32'h4000_0040, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
    #2;
    chk("t4_held_before", 64'(held_tran), 64'd1);
    tick();
    HRESET = 1'b1;
    #2;
    chk("t4_rst_held", 64'(held_tran),  64'd0);
    chk("t4_rst_hro",  64'(HREADYOUTS), 64'd1);
    tick();
    HRESET = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000);
    #2;
    chk("t4_after_held", 64'(held_tran),  64'd0);
    chk("t4_after_hro",  64'(HREADYOUTS), 64'd1);
    chk("t4_after_sel",  64'(sel_dec),    64'd0);
    tick();

    // 5: two-cycle ERROR response passes through
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000);
    #2;
    chk("t5_resp1", 64'(HRESPS),     64'd1);
    chk("t5_hro1",  64'(HREADYOUTS), 64'd0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 3'b000);
    #2;
    chk("t5_resp2", 64'(HRESPS),     64'd1);
    chk("t5_hro2",  64'(HREADYOUTS), 64'd1);
    tick();

    // 6: INCR4 burst, beat 2 granted late
    ba = 32'h0000_1100;
    drive(1'b1, 2'b10, ba, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b011);
    tick();
    drive(1'b1, 2'b11, ba + 32'd4, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b011);
    #2;
    chk("t6_b2_held", 64'(held_tran), 64'd0);
    tick();
    drive(1'b1, 2'b11, ba + 32'd8, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b011);
    #2;
    chk("t6_replay_held",  64'(held_tran), 64'd1);
    chk("t6_replay_addr",  64'(addr_in),   64'h0000_1104);
    chk("t6_replay_trans", 64'(trans_dec), 64'h3);
    tick();
    drive(1'b1, 2'b11, ba + 32'd8, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b011);
    #2;
    chk("t6_b3_held", 64'(held_tran), 64'd0);
    chk("t6_b3_addr", 64'(addr_in),   64'h0000_1108);
    tick();
    drive(1'b1, 2'b11, ba + 32'd12, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b011);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000);
    tick(); tick();

    chk("deliveries_total", 64'(n_deliv),      64'd6);
    chk("queue_drained",    64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
